// File: rtl/sdp_bram_64w16r_pkg.sv
// Shared geometry of the 64-bit-write / 16-bit-read staging buffer.
// Read addresses are {word, lane}; lane 0 is the least-significant half-word.
package sdp_bram_64w16r_pkg;

    localparam int SDPB_WR_DW     = 64;
    localparam int SDPB_WR_AW     = 7;
    localparam int SDPB_RD_DW     = 16;
    localparam int SDPB_LANE_BITS = 2;
    localparam int SDPB_RD_AW     = SDPB_WR_AW + SDPB_LANE_BITS;

endpackage

// File: rtl/sdp_bram_64w16r_lane_mux.sv
// Selects one read-width lane out of a full write-width word (little-endian lanes).
module sdp_bram_64w16r_lane_mux #(
    parameter int RD_DATA_WIDTH = 16,
    parameter int LANE_BITS     = 2
) (
    input  logic [RD_DATA_WIDTH*(2**LANE_BITS)-1:0] word,
    input  logic [LANE_BITS-1:0]                    lane,
    output logic [RD_DATA_WIDTH-1:0]                q
);

    localparam int NUM_LANES = 2**LANE_BITS;

    logic [RD_DATA_WIDTH-1:0] lanes [NUM_LANES];

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign lanes[gi] = word[gi*RD_DATA_WIDTH +: RD_DATA_WIDTH];
        end
    endgenerate

    assign q = lanes[lane];

endmodule

// File: rtl/sdp_bram_64w16r.sv
// Simple-dual-port RAM: 64-bit write port, 16-bit registered read port, one clock.
// Reset clears only the read output register(s); storage is never cleared.
module sdp_bram_64w16r
    import sdp_bram_64w16r_pkg::*;
#(
    parameter int WR_DATA_WIDTH = SDPB_WR_DW,
    parameter int WR_ADDR_WIDTH = SDPB_WR_AW,
    parameter int RD_DATA_WIDTH = SDPB_RD_DW,
    parameter int LANE_BITS     = SDPB_LANE_BITS,
    parameter int OUT_REG       = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 cea,
    input  logic [WR_ADDR_WIDTH-1:0]             ada,
    input  logic [WR_DATA_WIDTH-1:0]             din,
    input  logic                                 ceb,
    input  logic [WR_ADDR_WIDTH+LANE_BITS-1:0]   adb,
    output logic [RD_DATA_WIDTH-1:0]             dout
);

    localparam int RD_ADDR_WIDTH = WR_ADDR_WIDTH + LANE_BITS;
    localparam int DEPTH         = 2**WR_ADDR_WIDTH;

    logic [WR_DATA_WIDTH-1:0] mem [DEPTH];

    logic [WR_ADDR_WIDTH-1:0] rd_word;
    logic [LANE_BITS-1:0]     rd_lane;
    logic [WR_DATA_WIDTH-1:0] rd_data;
    logic [RD_DATA_WIDTH-1:0] lane_data;
    logic [RD_DATA_WIDTH-1:0] rd_reg;

    always_ff @(posedge clk) begin
        if (cea) begin
            mem[ada] <= din;
        end
    end

    assign rd_word = adb[RD_ADDR_WIDTH-1:LANE_BITS];
    assign rd_lane = adb[LANE_BITS-1:0];
    assign rd_data = mem[rd_word];

    sdp_bram_64w16r_lane_mux #(
        .RD_DATA_WIDTH (RD_DATA_WIDTH),
        .LANE_BITS     (LANE_BITS)
    ) u_lane_mux (
        .word (rd_data),
        .lane (rd_lane),
        .q    (lane_data)
    );

    // Sampling the array before the write lands gives read-first collisions.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_reg <= '0;
        end else if (ceb) begin
            rd_reg <= lane_data;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [RD_DATA_WIDTH-1:0] pipe_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    pipe_reg <= '0;
                end else if (ceb) begin
                    pipe_reg <= rd_reg;
                end
            end

            assign dout = pipe_reg;
        end else begin : g_no_out_reg
            assign dout = rd_reg;
        end
    endgenerate

endmodule

// File: tb/tb_sdp_bram_64w16r.sv
// Self-checking bench: a 1-cycle and a 2-cycle latency instance share all inputs.
module tb_sdp_bram_64w16r;

    logic        clk = 1'b0;
    logic        reset;
    logic        cea;
    logic [6:0]  ada;
    logic [63:0] din;
    logic        ceb;
    logic [8:0]  adb;
    logic [15:0] dout0;
    logic [15:0] dout1;

    logic [63:0] model [128];
    logic [15:0] exp_q  [$];
    logic [15:0] exp1_q [$];
    logic [15:0] basic_tbl [4];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdp_bram_64w16r #(.OUT_REG(0)) dut (
        .clk   (clk),
        .reset (reset),
        .cea   (cea),
        .ada   (ada),
        .din   (din),
        .ceb   (ceb),
        .adb   (adb),
        .dout  (dout0)
    );

    sdp_bram_64w16r #(.OUT_REG(1)) dut_p (
        .clk   (clk),
        .reset (reset),
        .cea   (cea),
        .ada   (ada),
        .din   (din),
        .ceb   (ceb),
        .adb   (adb),
        .dout  (dout1)
    );

    function automatic logic [15:0] model_lane(input logic [8:0] a);
        logic [63:0] w;
        w = model[a[8:2]];
        return w[16*a[1:0] +: 16];
    endfunction

    function automatic logic [63:0] sweep_word(input logic [6:0] w);
        logic [63:0] d;
        for (int l = 0; l < 4; l++) begin
            d[16*l +: 16] = {w, 9'h0} | 16'(l);
        end
        return d;
    endfunction

    task automatic write_word(input logic [6:0] a, input logic [63:0] d);
        @(negedge clk);
        cea = 1'b1;
        ada = a;
        din = d;
        @(posedge clk);
        model[a] = d;
        #1;
        cea = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] e;
        @(negedge clk);
        reset = 1'b1;
        ceb   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        e = 16'h0000;
        checks++;
        if (dout0 !== e) begin
            errors++;
            $display("FAIL reset_dout0: got %h expected %h", dout0, e);
        end
        checks++;
        if (dout1 !== e) begin
            errors++;
            $display("FAIL reset_dout1: got %h expected %h", dout1, e);
        end
        @(negedge clk);
        reset = 1'b0;
        ceb   = 1'b0;
        $display("reset: dout0=%h dout1=%h", dout0, dout1);
    endtask

    task automatic test_basic();
        logic [15:0] e;
        write_word(7'd0, 64'h4444_3333_2222_1111);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ceb = 1'b1;
            adb = 9'(i);
            exp_q.push_back(basic_tbl[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (dout0 !== e) begin
                errors++;
                $display("FAIL basic adb=%0d: got %h expected %h", i, dout0, e);
            end
            $display("basic: adb=%0d dout=%h", i, dout0);
        end
        @(negedge clk);
        ceb = 1'b0;
    endtask

    task automatic test_out_reg1();
        logic [15:0] e;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ceb = 1'b1;
            if (i < 4) begin
                adb = 9'(i);
                exp1_q.push_back(basic_tbl[i]);
            end
            @(posedge clk);
            #1;
            if (i >= 1) begin
                e = exp1_q.pop_front();
                checks++;
                if (dout1 !== e) begin
                    errors++;
                    $display("FAIL out_reg1 adb=%0d: got %h expected %h", i - 1, dout1, e);
                end
                $display("out_reg1: adb=%0d dout=%h", i - 1, dout1);
            end
        end
        @(negedge clk);
        ceb = 1'b0;
    endtask

    task automatic test_sweep();
        logic [15:0] e;
        int bad = 0;
        for (int w = 0; w < 128; w++) begin
            write_word(7'(w), sweep_word(7'(w)));
        end
        for (int a = 0; a < 512; a++) begin
            @(negedge clk);
            ceb = 1'b1;
            adb = 9'(a);
            exp_q.push_back(model_lane(9'(a)));
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (dout0 !== e) begin
                errors++;
                bad++;
                $display("FAIL sweep adb=%0d: got %h expected %h", a, dout0, e);
            end
        end
        $display("sweep: 512 half-words read, %0d wrong, last dout=%h", bad, dout0);
        @(negedge clk);
        ceb = 1'b0;
    endtask

    task automatic test_enables();
        logic [15:0] e;
        logic [15:0] held;
        @(negedge clk);
        cea = 1'b0;
        ada = 7'd5;
        din = '1;
        @(posedge clk);
        for (int a = 20; a < 24; a++) begin
            @(negedge clk);
            ceb = 1'b1;
            adb = 9'(a);
            exp_q.push_back(model_lane(9'(a)));
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (dout0 !== e) begin
                errors++;
                $display("FAIL cea_low adb=%0d: got %h expected %h", a, dout0, e);
            end
            $display("cea_low: adb=%0d dout=%h", a, dout0);
        end
        held = model_lane(9'd7);
        @(negedge clk);
        adb = 9'd7;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ceb = 1'b0;
            adb = 9'(100 + 100 * k);
            @(posedge clk);
            #1;
            checks++;
            if (dout0 !== held) begin
                errors++;
                $display("FAIL ceb_hold adb=%0d: got %h expected %h", adb, dout0, held);
            end
            $display("ceb_hold: adb=%0d dout=%h", adb, dout0);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] e;
        write_word(7'd10, 64'h0000_0000_BEEF_0000);
        @(negedge clk);
        ceb = 1'b1;
        adb = 9'd41;
        exp_q.push_back(16'hBEEF);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (dout0 !== e) begin
            errors++;
            $display("FAIL pre_reset_read: got %h expected %h", dout0, e);
        end
        @(negedge clk);
        reset = 1'b1;
        cea   = 1'b1;
        ada   = 7'd20;
        din   = 64'hCAFE_F00D_5A5A_1234;
        @(posedge clk);
        model[20] = din;
        #1;
        checks++;
        if (dout0 !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reset_dout0: got %h expected 0000", dout0);
        end
        checks++;
        if (dout1 !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reset_dout1: got %h expected 0000", dout1);
        end
        $display("mid_reset: dout0=%h dout1=%h", dout0, dout1);
        @(negedge clk);
        reset = 1'b0;
        cea   = 1'b0;
        exp_q.push_back(16'hBEEF);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (dout0 !== e) begin
            errors++;
            $display("FAIL post_reset_read: got %h expected %h", dout0, e);
        end
        @(negedge clk);
        adb = 9'd80;
        exp_q.push_back(16'h1234);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (dout0 !== e) begin
            errors++;
            $display("FAIL write_in_reset: got %h expected %h", dout0, e);
        end
        $display("post_reset: adb=80 dout=%h", dout0);
    endtask

    task automatic test_collision();
        logic [15:0] e;
        @(negedge clk);
        cea = 1'b1;
        ada = 7'd2;
        din = 64'h1357_9BDF_2468_ACE0;
        ceb = 1'b1;
        adb = 9'd8;
        exp_q.push_back(model_lane(9'd8));
        @(posedge clk);
        model[2] = din;
        #1;
        e = exp_q.pop_front();
        checks++;
        if (dout0 !== e) begin
            errors++;
            $display("FAIL collision_old: got %h expected %h", dout0, e);
        end
        $display("collision: dout=%h", dout0);
        @(negedge clk);
        cea = 1'b0;
        exp_q.push_back(16'hACE0);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (dout0 !== e) begin
            errors++;
            $display("FAIL collision_new: got %h expected %h", dout0, e);
        end
        $display("collision_next: dout=%h", dout0);
        @(negedge clk);
        ceb = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        cea   = 1'b0;
        ceb   = 1'b0;
        ada   = '0;
        din   = '0;
        adb   = '0;
        basic_tbl[0] = 16'h1111;
        basic_tbl[1] = 16'h2222;
        basic_tbl[2] = 16'h3333;
        basic_tbl[3] = 16'h4444;
        for (int i = 0; i < 128; i++) begin
            model[i] = '0;
        end
        test_reset();
        test_basic();
        test_out_reg1();
        test_sweep();
        test_enables();
        test_reset_mid();
        test_collision();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
